// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounced switch event controller.
package debounce_pkg;

   localparam int DEF_N_CH         = 4;
   localparam int DEF_TICK_DIV     = 1000;
   localparam int DEF_STABLE_TICKS = 16;

   localparam logic EVT_PRESS   = 1'b1;
   localparam logic EVT_RELEASE = 1'b0;

   // Channel index width; a single channel still needs one bit.
   function automatic int ch_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_event_ctrl_if.sv
// Valid/ready event port carrying channel index and press/release direction.
interface debounce_event_ctrl_if
   import debounce_pkg::*;
#(
   parameter int N_CH = DEF_N_CH
);

   localparam int CH_W = ch_width(N_CH);

   logic            evt_valid;
   logic            evt_ready;
   logic [CH_W-1:0] evt_channel;
   logic            evt_press;

   modport master (
      output evt_valid,
      output evt_channel,
      output evt_press,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_channel,
      input  evt_press,
      output evt_ready
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester after the last grant, wrapping modulo N_CH.
module rr_arbiter
   import debounce_pkg::*;
#(
   parameter  int N_CH = DEF_N_CH,
   localparam int CH_W = ch_width(N_CH)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [N_CH-1:0] req,
   input  logic            advance,
   output logic            grant_valid,
   output logic [CH_W-1:0] grant_idx
);

   logic [CH_W-1:0] last_grant;

   always_comb begin
      int unsigned j;
      j           = 0;
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         j = (32'(last_grant) + k) % N_CH;
         if (!grant_valid && req[j[CH_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = j[CH_W-1:0];
         end
      end
   end

   // Reset points at the last channel so channel 0 wins first.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_grant <= CH_W'(N_CH - 1);
      end else if (advance && grant_valid) begin
         last_grant <= grant_idx;
      end
   end

endmodule

// File: rtl/debounce_event_ctrl.sv
// Multi-channel switch debouncer sharing one sample-tick prescaler, with a
// per-channel pending event drained through a round-robin valid/ready port.
module debounce_event_ctrl
   import debounce_pkg::*;
#(
   parameter int N_CH         = DEF_N_CH,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [N_CH-1:0]       switch_in,
   output logic [N_CH-1:0]       switch_state,
   output logic [N_CH-1:0]       overflow,
   input  logic [N_CH-1:0]       clr_overflow,
   debounce_event_ctrl_if.master evt
);

   localparam int CH_W  = ch_width(N_CH);
   localparam int PS_W  = $clog2(TICK_DIV);
   localparam int CNT_W = $clog2(STABLE_TICKS + 1);

   logic [N_CH-1:0] sync_q1;
   logic [N_CH-1:0] sync_q2;
   logic [N_CH-1:0] pend;
   logic [N_CH-1:0] pend_dir;
   logic [N_CH-1:0] flip;
   logic [N_CH-1:0] granted;
   logic [N_CH-1:0] ovf_set;
   logic [PS_W-1:0] ps_cnt;
   logic            tick;
   logic            load;
   logic            grant_valid;
   logic [CH_W-1:0] grant_idx;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= switch_in;
         sync_q2 <= sync_q1;
      end
   end

   assign tick = (ps_cnt == PS_W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!resetn)   ps_cnt <= '0;
      else if (tick) ps_cnt <= '0;
      else           ps_cnt <= ps_cnt + PS_W'(1);
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;

      assign flip[i] = tick && (sync_q2[i] != switch_state[i])
                       && (cnt == CNT_W'(STABLE_TICKS - 1));

      always_ff @(posedge clk) begin
         if (!resetn) begin
            cnt <= '0;
         end else if (tick) begin
            if ((sync_q2[i] == switch_state[i]) || flip[i]) cnt <= '0;
            else                                            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign load = !evt.evt_valid || evt.evt_ready;

   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .clk         (clk),
      .resetn      (resetn),
      .req         (pend),
      .advance     (load),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign granted = (load && grant_valid) ? (N_CH'(1) << grant_idx) : '0;
   // A channel granted this cycle hands off its old event, so no overflow.
   assign ovf_set = flip & pend & ~granted;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         switch_state <= '0;
         pend         <= '0;
         pend_dir     <= '0;
         overflow     <= '0;
      end else begin
         switch_state <= switch_state ^ flip;
         pend         <= (pend & ~granted) | flip;
         pend_dir     <= (pend_dir & ~flip) | (sync_q2 & flip);
         overflow     <= (overflow & ~clr_overflow) | ovf_set;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         evt.evt_valid   <= 1'b0;
         evt.evt_channel <= '0;
         evt.evt_press   <= 1'b0;
      end else if (load) begin
         evt.evt_valid <= grant_valid;
         if (grant_valid) begin
            evt.evt_channel <= grant_idx;
            evt.evt_press   <= pend_dir[grant_idx];
         end
      end
   end

endmodule

// File: tb/tb_debounce_event_ctrl.sv
// Bench for debounce_event_ctrl: directed scenarios plus random traffic,
// checked every cycle against a behavioural model.
module tb_debounce_event_ctrl;
   import debounce_pkg::*;

   localparam int N_CH         = 4;
   localparam int TICK_DIV     = 4;
   localparam int STABLE_TICKS = 3;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic [N_CH-1:0] switch_in = '0;
   logic [N_CH-1:0] clr_overflow = '0;
   logic [N_CH-1:0] switch_state;
   logic [N_CH-1:0] overflow;
   logic            evt_ready = 1'b0;

   debounce_event_ctrl_if #(.N_CH(N_CH)) evt_if ();
   assign evt_if.evt_ready = evt_ready;

   debounce_event_ctrl #(
      .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .switch_in    (switch_in),
      .switch_state (switch_state),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .evt          (evt_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;
   int dlog[$];
   int mlog[$];
   int exp_q[$];

   bit [N_CH-1:0] m_s1, m_s2, m_state, m_pend, m_dir, m_ovf;
   int            m_pc, m_last, m_chan;
   int            m_run[N_CH];
   bit            m_valid, m_press;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_state = '0; m_pend = '0; m_dir = '0; m_ovf = '0;
      m_pc = 0; m_last = N_CH - 1; m_chan = 0; m_valid = 1'b0; m_press = 1'b0;
      for (int i = 0; i < N_CH; i++) m_run[i] = 0;
   endtask

   // Rules: grant from pending set (round robin), then debounce on tick.
   task automatic model_step();
      bit tick, load;
      int g, j;
      if (resetn !== 1'b1) begin
         model_reset();
         return;
      end
      tick = (m_pc == TICK_DIV - 1);
      load = !m_valid || (evt_ready === 1'b1);
      if (load) begin
         if (m_valid) mlog.push_back(m_chan * 2 + int'(m_press));
         g = -1;
         for (int k = 1; k <= N_CH; k++) begin
            j = (m_last + k) % N_CH;
            if (g < 0 && m_pend[j]) g = j;
         end
         if (g >= 0) begin
            m_valid = 1'b1; m_chan = g; m_press = m_dir[g]; m_pend[g] = 1'b0; m_last = g;
         end else begin
            m_valid = 1'b0;
         end
      end
      m_ovf &= ~clr_overflow;
      if (tick) begin
         for (int c = 0; c < N_CH; c++) begin
            if (m_s2[c] == m_state[c]) begin
               m_run[c] = 0;
            end else begin
               m_run[c]++;
               if (m_run[c] == STABLE_TICKS) begin
                  m_run[c]   = 0;
                  m_state[c] = m_s2[c];
                  if (m_pend[c]) m_ovf[c] = 1'b1;
                  m_pend[c] = 1'b1;
                  m_dir[c]  = m_s2[c];
               end
            end
         end
      end
      m_pc = (m_pc + 1) % TICK_DIV;
      m_s2 = m_s1;
      m_s1 = switch_in;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("switch_state", 32'(switch_state), 32'(m_state));
         check("overflow", 32'(overflow), 32'(m_ovf));
         check("evt_valid", 32'(evt_if.evt_valid), 32'(m_valid));
         if (m_valid) begin
            check("evt_channel", 32'(evt_if.evt_channel), 32'(m_chan));
            check("evt_press", 32'(evt_if.evt_press), 32'(m_press));
         end
         if (evt_if.evt_valid === 1'b1 && evt_ready === 1'b1)
            dlog.push_back(int'(evt_if.evt_channel) * 2 + int'(evt_if.evt_press));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      switch_in = '0; clr_overflow = '0; resetn = 1'b0;
      step(1);
      resetn = 1'b1;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (evt_if.evt_valid !== 1'b1 && n < 60) begin step(1); n++; end
      check(name, 32'(n < 60), 32'd1);
   endtask

   task automatic wait_state(input int ch, input bit lvl, input string name);
      int n = 0;
      while (switch_state[ch] !== lvl && n < 60) begin step(1); n++; end
      check(name, 32'(n < 60), 32'd1);
   endtask

   // Compares DUT-observed and model acceptances from mark against exp_q.
   task automatic expect_log(input string name, input int mark);
      check({name, "_count"}, 32'(dlog.size() - mark), 32'(exp_q.size()));
      check({name, "_mcount"}, 32'(mlog.size() - mark), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (mark + i < dlog.size()) check(name, 32'(dlog[mark + i]), 32'(exp_q[i]));
         if (mark + i < mlog.size()) check({name, "_m"}, 32'(mlog[mark + i]), 32'(exp_q[i]));
      end
   endtask

   initial begin
      int n, mark, ch;

      step(1);
      chk_en = 1'b1;
      check("rst_switch_state", 32'(switch_state), 32'd0);
      check("rst_evt_valid", 32'(evt_if.evt_valid), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      resetn = 1'b1;

      // Clean press on channel 2.
      evt_ready = 1'b1;
      mark = dlog.size();
      switch_in[2] = 1'b1;
      n = 0;
      while (switch_state[2] !== 1'b1 && n < 40) begin step(1); n++; end
      check("press_latency", 32'(n >= 11 && n <= 14), 32'd1);
      check("press_not_yet_valid", 32'(evt_if.evt_valid), 32'd0);
      step(1);
      check("press_valid", 32'(evt_if.evt_valid), 32'd1);
      check("press_channel", 32'(evt_if.evt_channel), 32'd2);
      check("press_dir", 32'(evt_if.evt_press), 32'(EVT_PRESS));
      step(1);
      check("press_one_cycle", 32'(evt_if.evt_valid), 32'd0);
      exp_q = '{5};
      expect_log("press_log", mark);

      // Bounce rejection on channel 0.
      do_reset();
      mark = dlog.size();
      for (int t = 0; t < 8; t++) begin
         switch_in[0] = ~switch_in[0];
         step(5);
      end
      switch_in[0] = 1'b0;
      step(30);
      check("bounce_state", 32'(switch_state[0]), 32'd0);
      check("bounce_overflow", 32'(overflow), 32'd0);
      exp_q = '{};
      expect_log("bounce_log", mark);

      // Simultaneous presses on ch1 and ch3 while the consumer stalls.
      do_reset();
      evt_ready = 1'b0;
      switch_in[1] = 1'b1; switch_in[3] = 1'b1;
      wait_valid("simul_wait");
      check("simul_first_ch", 32'(evt_if.evt_channel), 32'd1);
      step(5);
      check("simul_hold_ch", 32'(evt_if.evt_channel), 32'd1);
      check("simul_hold_dir", 32'(evt_if.evt_press), 32'd1);
      mark = dlog.size();
      evt_ready = 1'b1;
      step(4);
      exp_q = '{3, 7};
      expect_log("simul_log", mark);
      check("simul_drained", 32'(evt_if.evt_valid), 32'd0);

      // Round-robin between ch0 and ch1 across press/release/press.
      do_reset();
      evt_ready = 1'b1;
      mark = dlog.size();
      for (int r = 0; r < 3; r++) begin
         switch_in[1:0] = (r % 2 == 0) ? 2'b11 : 2'b00;
         step(24);
      end
      exp_q = '{1, 3, 0, 2, 1, 3};
      expect_log("rr_log", mark);

      // Overflow: ch1 occupies the port, ch2 press is overwritten by release.
      do_reset();
      evt_ready = 1'b0;
      switch_in[1] = 1'b1;
      wait_valid("ovf_wait_valid");
      switch_in[2] = 1'b1;
      wait_state(2, 1'b1, "ovf_wait_press");
      switch_in[2] = 1'b0;
      wait_state(2, 1'b0, "ovf_wait_release");
      step(1);
      check("ovf_set", 32'(overflow), 32'h4);
      check("ovf_model_pin", 32'(m_ovf), 32'h4);
      mark = dlog.size();
      evt_ready = 1'b1;
      step(4);
      exp_q = '{3, 4};
      expect_log("ovf_log", mark);
      evt_ready = 1'b0;
      clr_overflow[2] = 1'b1;
      step(1);
      clr_overflow = '0;
      check("ovf_cleared", 32'(overflow), 32'd0);

      // Reset while an event is presented and another is pending.
      do_reset();
      evt_ready = 1'b0;
      switch_in[1:0] = 2'b11;
      wait_valid("rstmid_wait");
      check("rstmid_first_ch", 32'(evt_if.evt_channel), 32'd0);
      step(1);
      check("rstmid_ch1_pending", 32'(m_pend[1]), 32'd1);
      resetn = 1'b0; switch_in = '0;
      step(1);
      check("rstmid_valid", 32'(evt_if.evt_valid), 32'd0);
      check("rstmid_state", 32'(switch_state), 32'd0);
      check("rstmid_overflow", 32'(overflow), 32'd0);
      resetn = 1'b1;
      evt_ready = 1'b1;
      mark = dlog.size();
      step(40);
      exp_q = '{};
      expect_log("rstmid_log", mark);

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(9) == 0) begin
            ch = $urandom_range(N_CH - 1);
            switch_in[ch] = ~switch_in[ch];
         end
         evt_ready    = ($urandom_range(2) != 0);
         clr_overflow = ($urandom_range(15) == 0) ? N_CH'($urandom) : '0;
         resetn       = ($urandom_range(499) != 0);
         step(1);
      end
      resetn = 1'b1;
      clr_overflow = '0;
      step(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
